// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared definitions for the round-robin 4:1 output-channel arbiter.
//   - state_e       : arbiter FSM encoding (IDLE / GRANT)
//   - SRC_A..SRC_D  : source indices, also the mux select encoding
//   - DEFAULT_BURST : default maximum accepted beats per grant
//   - rr_pick_t     : result of one round-robin scan (found flag + winner)
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    localparam int DEFAULT_BURST = 4;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Bundles the four requesters, their data, and the downstream channel.
//   Signals:
//     req[3:0]     request per source (bit0=A .. bit3=D), level-sensitive
//     a,b,c,d      2-bit source data, sampled only while that source is granted
//     y[1:0]       muxed data, 2'b00 when no grant is active
//     y_valid      a beat is offered on y
//     y_ready      consumer can take the beat
//     gnt[3:0]     one-hot grant, same order as req; 4'b0000 when idle
//     sel[1:0]     current / last granted source
//     last         final beat of the burst (qualified by y_valid)
//   Handshake: a beat transfers on a rising clk edge where y_valid and
//   y_ready are both high. While y_valid is high and y_ready is low, the
//   grant, the beat counter and y hold, and the granted source must keep
//   its data stable. y_valid follows req of the granted source, so a source
//   withdraws its offer by dropping req, which also ends its burst.
//   Modports: slave = arbiter side, master = requester/consumer side.
interface mux_rr_arbiter_if;

    logic [3:0] req;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic [1:0] d;
    logic [1:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       last;

    modport slave (
        input  req, a, b, c, d, y_ready,
        output y, y_valid, gnt, sel, last
    );

    modport master (
        output req, a, b, c, d, y_ready,
        input  y, y_valid, gnt, sel, last
    );

endinterface

// File: rtl/mux_rr_arbiter_mux4_2b.sv
// mux4_2b
//   Purely combinational 4:1 multiplexer for 2-bit data.
//   Ports:
//     sel_i[1:0]   0=A, 1=B, 2=C, 3=D
//     en_i         when low, y_o is forced to 2'b00
//     a_i..d_i     2-bit data inputs
//     y_o[1:0]     selected data
module mux4_2b
    import mux_rr_arbiter_pkg::*;
(
    input  logic [1:0] sel_i,
    input  logic       en_i,
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic [1:0] c_i,
    input  logic [1:0] d_i,
    output logic [1:0] y_o
);

    always_comb begin
        y_o = 2'b00;
        if (en_i) begin
            case (sel_i)
                SRC_A:   y_o = a_i;
                SRC_B:   y_o = b_i;
                SRC_C:   y_o = c_i;
                default: y_o = d_i;
            endcase
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one 2-bit output channel between four
//   requesters. The winner holds the channel for up to BURST accepted
//   beats; the consumer applies backpressure with y_ready.
//   Parameters:
//     BURST        maximum accepted beats per grant (1..15)
//     CNT_W        beat counter width, 2**CNT_W > BURST
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          mux_rr_arbiter_if.slave (requests, data, output channel)
//     dbg_state_o  current FSM state
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int BURST = DEFAULT_BURST,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_rr_arbiter_if.slave       bus,
    output state_e                dbg_state_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q,   sel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [3:0] gnt_c;
    logic       mux_en_c;
    logic       y_valid_c;
    logic       last_c;
    logic       accept_c;
    logic       burst_end_c;
    rr_pick_t   pick_c;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4). Passing the just-served
    // source as ptr ranks it last, so it only wins when it is alone.
    function automatic rr_pick_t rr_next(input logic [1:0] ptr,
                                         input logic [3:0] r);
        rr_pick_t   p;
        logic [1:0] idx;
        p = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!p.found && r[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SRC_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        gnt_c       = 4'b0000;
        mux_en_c    = 1'b0;
        y_valid_c   = 1'b0;
        last_c      = 1'b0;
        accept_c    = 1'b0;
        burst_end_c = 1'b0;
        pick_c      = rr_next(sel_q, bus.req);

        case (state_q)
            ST_IDLE: begin
                if (pick_c.found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_c.idx;
                    cnt_d   = '0;
                end
            end

            default: begin
                gnt_c     = 4'b0001 << sel_q;
                mux_en_c  = 1'b1;
                y_valid_c = bus.req[sel_q];
                last_c    = y_valid_c && (cnt_q == LAST_CNT);
                accept_c  = y_valid_c && bus.y_ready;
                // A withdrawn request ends the burst without a transfer;
                // otherwise only the accepted final beat ends it. Both
                // conditions feed one decision, so the pointer advances once.
                burst_end_c = !y_valid_c || (accept_c && (cnt_q == LAST_CNT));

                if (burst_end_c) begin
                    cnt_d = '0;
                    if (pick_c.found) begin
                        sel_d = pick_c.idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept_c) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    mux4_2b u_mux (
        .sel_i (sel_q),
        .en_i  (mux_en_c),
        .a_i   (bus.a),
        .b_i   (bus.b),
        .c_i   (bus.c),
        .d_i   (bus.d),
        .y_o   (bus.y)
    );

    assign bus.gnt     = gnt_c;
    assign bus.sel     = sel_q;
    assign bus.y_valid = y_valid_c;
    assign bus.last    = last_c;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    import mux_rr_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_rr_arbiter_if bus ();
    state_e dbg_state;

    mux_rr_arbiter #(.BURST(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- vectors / scoreboard ----------------
    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       on;     // a grant is expected this cycle
        logic [1:0] sel;    // expected sel (granted or last winner)
        logic       valid;
        logic       last;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];   // {gnt, y, last} of each expected accepted beat
    int         total = 0;
    int         bad   = 0;
    logic       prev_stall;

    function automatic vec_t mk(input logic [3:0] r, input logic rdy,
                                input logic on, input logic [1:0] s,
                                input logic val, input logic lst);
        vec_t v;
        v.req = r; v.rdy = rdy; v.on = on; v.sel = s; v.valid = val; v.last = lst;
        return v;
    endfunction

    function automatic logic [1:0] src_data(input logic [1:0] s);
        case (s)
            2'd0:    return bus.a;
            2'd1:    return bus.b;
            2'd2:    return bus.c;
            default: return bus.d;
        endcase
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [1:0] exp_sel);
        check({name, "_gnt"},   0, 7'(bus.gnt),     7'd0);
        check({name, "_y"},     0, 7'(bus.y),       7'd0);
        check({name, "_valid"}, 0, 7'(bus.y_valid), 7'd0);
        check({name, "_last"},  0, 7'(bus.last),    7'd0);
        check({name, "_sel"},   0, 7'(bus.sel),     7'(exp_sel));
        check({name, "_state"}, 0, 7'(dbg_state),   7'(ST_IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req = 4'b0000; bus.y_ready = 1'b0;
        bus.a = 2'b00; bus.b = 2'b00; bus.c = 2'b00; bus.d = 2'b00;
        prev_stall = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset", 2'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input string name, input int idx, input vec_t v);
        logic [3:0] eg;
        logic [1:0] ey;
        @(posedge clk); #1;
        bus.req     = v.req;
        bus.y_ready = v.rdy;
        if (!prev_stall) begin
            bus.a = 2'($urandom_range(0, 3));
            bus.b = 2'($urandom_range(0, 3));
            bus.c = 2'($urandom_range(0, 3));
            bus.d = 2'($urandom_range(0, 3));
        end
        prev_stall = v.on && v.valid && !v.rdy;
        eg = v.on ? (4'b0001 << v.sel) : 4'b0000;
        ey = v.on ? src_data(v.sel) : 2'b00;
        if (v.on && v.valid && v.rdy) exp_q.push_back({eg, ey, v.last});

        @(negedge clk);
        check({name, "_gnt"},   idx, 7'(bus.gnt),     7'(eg));
        check({name, "_y"},     idx, 7'(bus.y),       7'(ey));
        check({name, "_valid"}, idx, 7'(bus.y_valid), 7'(v.valid));
        check({name, "_last"},  idx, 7'(bus.last),    7'(v.last));
        check({name, "_sel"},   idx, 7'(bus.sel),     7'(v.sel));
        check({name, "_state"}, idx, 7'(dbg_state),   v.on ? 7'(ST_GRANT) : 7'(ST_IDLE));
        if (bus.y_valid && bus.y_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL %s_beat[%0d]: got unexpected beat gnt=%0h y=%0h expected none",
                         name, idx, bus.gnt, bus.y);
            end else begin
                check({name, "_beat"}, idx, {bus.gnt, bus.y, bus.last}, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) run_vec(name, i, vecs[i]);
        check({name, "_drain"}, 0, 7'(exp_q.size()), 7'd0);
        exp_q.delete();
        vecs.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0;
        bus.req = 4'b0000; bus.y_ready = 1'b0;
        bus.a = 2'b00; bus.b = 2'b00; bus.c = 2'b00; bus.d = 2'b00;
        prev_stall = 1'b0;

        // All four requesting: A,B,C,D bursts of 4 back to back, then A again.
        do_reset();
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        for (int i = 1; i < 18; i++)
            vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'((i - 1) / 4), 1'b1, ((i - 1) % 4) == 3));
        run_table("rr_all");

        // Only C requesting: regranted with no bubble.
        do_reset();
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        for (int i = 1; i < 13; i++)
            vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, ((i - 1) % 4) == 3));
        run_table("c_only");

        // A stalled for 3 cycles after its first beat; then req drops and
        // the arbiter idles with sel kept at A; D then wins after one cycle.
        do_reset();
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0));
        run_table("stall_a");

        // B drops its request after 2 beats while D waits: D takes over.
        do_reset();
        vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0));
        run_table("b_drop");

        // Reset pulsed asynchronously in the middle of a C burst.
        do_reset();
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0));
        run_table("mid_c");
        @(posedge clk); #2;
        check("mid_c_before_rst_valid", 0, 7'(bus.y_valid), 7'd1);
        check("mid_c_before_rst_gnt",   0, 7'(bus.gnt),     7'b0000100);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #1;
        check_idle_outputs("async_rst", 2'd3);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        prev_stall = 1'b0;
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0));
        run_table("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
